cdf_lut_builder: RTL
====================

# cdf_lut_builder

Second stage of the histogram equalizer. It starts when `input_pipeline` signals done and scans the 256 histogram bins in scratchpad m2. For each bin it keeps a running cumulative count (CDF) and computes the equalized output level. It writes one lookup-table entry per bin into scratchpad m3, which the output-mapping stage later reads to remap m1 pixels into m4.

## Interface
- `PIXEL_COUNT`, 64: total pixels in the image, N. Must be ≤ 2^COUNT_W − 1.
- `COUNT_W`, 16: width of the bin count and CDF.
- `L_MAX`, 255: maximum output pixel level.
- `clock`  in  1: single clock, all logic on posedge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: level start, driven by the `input_pipeline` done output. Sampled only in IDLE.
- `baseOffset`  in  1: bank select for m2 reads and m3 writes.
- `m2ReadVal`  in  128: m2 read data, valid one cycle after `m2ReadAddr`.
- `m2ReadAddr`  out  16: `{7'd0, baseOffset, bin[7:0]}`.
- `m3WriteAddr`  out  16: `{7'd0, baseOffset, bin[7:0]}`.
- `m3WriteVal`  out  128: `{120'd0, level[7:0]}`.
- `m3WE`  out  1: one-cycle write strobe.
- `done`  out  1: high after bin 255 is written; holds until reset.

## Operation
- Bin word format:
  - If `m2ReadVal[31:16] == 16'hAAAA`, count = `m2ReadVal[15:0]`.
  - Otherwise count = 0 (bin never written).
- Per bin b, in order 0..255:
  - `cdf += count`.
  - `cdf_min` is latched as `cdf` at the first bin with a nonzero count. Before that, `cdf_min` = 0 and it is marked unset.
  - If `cdf_min` is unset, level = 0.
  - Otherwise level = ((cdf − cdf_min) × L_MAX) / (N − cdf_min), unsigned truncating division.
  - If the divisor is 0 (single-valued image), level = 0.
- Widths:
  - Numerator: COUNT_W + 8 = 24 bits.
  - Divisor: COUNT_W bits.
  - Quotient: ≤ L_MAX by construction. It is saturated to 8 bits defensively.
- FSM states and transitions:
  - IDLE: `start` → READ.
  - READ: drive `m2ReadAddr`.
  - WAIT: one-cycle memory latency.
  - ACCUM: update `cdf` and `cdf_min`, launch the divider.
  - DIVIDE: wait for divider done.
  - WRITE: assert `m3WE` with address/value for bin b. If b == 255 → DONE, else b++ → READ.
  - DONE: terminal; `done` = 1, `m3WE` = 0.
- ACCUM skips the divider and goes straight to WRITE with level 0 when `cdf_min` is unset or the divisor is 0.
- `start` dropping after leaving IDLE is ignored. `start` held high in DONE does not restart the block.
- `baseOffset` must be stable from `start` until `done`.

## Timing
- Reset values: all outputs 0. State = IDLE, b = 0, `cdf` = 0, `cdf_min` unset, divider idle.
- Reset mid-operation: on the next posedge all state returns to the reset values. The in-flight write is dropped and `m3WE` = 0 that cycle.
- Per bin with the divider used: READ 1 + WAIT 1 + ACCUM 1 + DIVIDE 24 + WRITE 1 = 28 cycles.
- Per bin with the divider skipped: 4 cycles.
- `m2ReadAddr` is registered. `m2ReadVal` is captured in ACCUM (the edge after WAIT).
- `m3WE` is high for exactly one cycle per bin, i.e. 256 pulses total, with addresses strictly increasing.
- `done` rises on the clock edge after the final WRITE and stays high until reset.

## Structure
- Shared package `histeq_pkg` holds:
  - `TAG_VALID = 16'hAAAA`
  - `NUM_BINS = 256`
  - `L_MAX`
  - the FSM state enum
  - the address-forming function `{7'd0, offset, bin}` (also used by `input_pipeline` and the output stage)
- Sub-module `seq_divider`: restoring divider, 24-bit dividend, 16-bit divisor, 24 iterations.
  - Ports: `start` pulse, `busy`, `done` pulse, `quotient[23:0]`, synchronous active-low `rst_n`.
  - Latency is exactly 24 cycles from `start` to `done`.

## Test plan
- N=64; bins 10:16, 20:16, 30:32, all others untagged → LUT:
  - 0..19 = 0
  - 20..29 = 85
  - 30..255 = 255
  - 256 writes, then `done`.
- All 64 pixels in bin 100 → all LUT entries 0 (divisor-zero path). Each bin takes 4 cycles; `done` arrives 1024 cycles after leaving IDLE.
- Bin 0 tag = `16'hAAAB` with count 5, bin 1 valid with count 64 → bin 0 treated as count 0, LUT[1] = 0, LUT[2..255] = 0 (`cdf_min` = 64 = N).
- `baseOffset` = 1 → all m2 reads in 0x0100–0x01FF and all m3 writes in 0x0100–0x01FF.
- `rst_n` low for one cycle during DIVIDE of bin 20 → outputs 0 next cycle, state IDLE. Re-asserting `start` regenerates the full, correct LUT.
- `start` held high after `done` → no further `m3WE` pulses and `done` stays 1.

Source files
------------

// File: rtl/histeq_pkg.sv
// Shared definitions for the histogram-equalizer stages: bin tagging, LUT
// geometry, the LUT-builder state encoding and scratchpad address forming.
package histeq_pkg;

    localparam logic [15:0] TAG_VALID = 16'hAAAA;
    localparam int unsigned NUM_BINS  = 256;
    localparam int unsigned L_MAX     = 255;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        ACCUM,
        DIVIDE,
        WRITE,
        DONE
    } lut_state_e;

    // Scratchpad word address: bank bit above the 8-bit bin index.
    function automatic logic [15:0] form_addr(input logic offset, input logic [7:0] bin);
        return {7'd0, offset, bin};
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle. The first bit is
// resolved on the start edge so done pulses exactly DIVIDEND_W cycles later.
module seq_divider #(
    parameter int DIVIDEND_W = 24,
    parameter int DIVISOR_W  = 16
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient
);

    localparam int REM_W = DIVISOR_W + 1;
    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    logic [REM_W-1:0]      rem_q, rem_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // The quotient register doubles as the dividend shift register.
    function automatic logic [REM_W+DIVIDEND_W-1:0] div_step(
        input logic [REM_W-1:0]      rem,
        input logic [DIVIDEND_W-1:0] quo,
        input logic [DIVISOR_W-1:0]  dvs
    );
        logic [REM_W-1:0] trial;
        trial = {rem[REM_W-2:0], quo[DIVIDEND_W-1]};
        if (trial >= {1'b0, dvs}) begin
            return {trial - {1'b0, dvs}, quo[DIVIDEND_W-2:0], 1'b1};
        end
        return {trial, quo[DIVIDEND_W-2:0], 1'b0};
    endfunction

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start && !busy_q) begin
            {rem_d, quo_d} = div_step('0, dividend, divisor);
            dvs_d  = divisor;
            cnt_d  = CNT_W'(1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            {rem_d, quo_d} = div_step(rem_q, quo_q, dvs_q);
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/cdf_lut_builder.sv
// Second equalizer stage: walks the 256 histogram bins in m2, accumulates the
// CDF and writes one equalized output level per bin into m3.
module cdf_lut_builder #(
    parameter int unsigned PIXEL_COUNT = 64,
    parameter int unsigned COUNT_W     = 16,
    parameter int unsigned L_MAX       = 255
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         start,
    input  logic         baseOffset,
    input  logic [127:0] m2ReadVal,
    output logic [15:0]  m2ReadAddr,
    output logic [15:0]  m3WriteAddr,
    output logic [127:0] m3WriteVal,
    output logic         m3WE,
    output logic         done
);

    import histeq_pkg::*;

    localparam int unsigned NUM_W    = COUNT_W + 8;
    localparam logic [7:0]  LAST_BIN = 8'(NUM_BINS - 1);

    lut_state_e         state_q, state_d;
    logic [7:0]         bin_q, bin_d;
    logic [COUNT_W-1:0] cdf_q, cdf_d;
    logic [COUNT_W-1:0] cdf_min_q, cdf_min_d;
    logic               min_set_q, min_set_d;
    logic [31:0]        word_q, word_d;
    logic [15:0]        m2_addr_q, m2_addr_d;
    logic [15:0]        m3_addr_q, m3_addr_d;
    logic [7:0]         level_q, level_d;
    logic               m3_we_q, m3_we_d;
    logic               done_q, done_d;

    logic [COUNT_W-1:0] bin_count, cdf_sum, min_now, cdf_delta, divisor;
    logic               min_now_set, skip_div;
    logic [NUM_W-1:0]   numerator, quotient;
    logic               div_start, div_done;
    logic               unused_div_busy, unused_rd_hi;

    function automatic logic [7:0] sat_level(input logic [NUM_W-1:0] q);
        return (|q[NUM_W-1:8]) ? 8'hFF : q[7:0];
    endfunction

    // Bin arithmetic for the word captured at the end of WAIT.
    always_comb begin
        bin_count   = (word_q[31:16] == TAG_VALID) ? COUNT_W'(word_q[15:0]) : '0;
        cdf_sum     = cdf_q + bin_count;
        min_now_set = min_set_q || (bin_count != '0);
        if (min_set_q) begin
            min_now = cdf_min_q;
        end else if (bin_count != '0) begin
            min_now = cdf_sum;
        end else begin
            min_now = '0;
        end
        cdf_delta = cdf_sum - min_now;
        divisor   = COUNT_W'(PIXEL_COUNT) - min_now;
        numerator = NUM_W'(cdf_delta) * NUM_W'(L_MAX);
        skip_div  = !min_now_set || (divisor == '0);
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no branch of the case infers a latch.
        state_d   = state_q;
        bin_d     = bin_q;
        cdf_d     = cdf_q;
        cdf_min_d = cdf_min_q;
        min_set_d = min_set_q;
        word_d    = word_q;
        m2_addr_d = m2_addr_q;
        m3_addr_d = m3_addr_q;
        level_d   = level_q;
        m3_we_d   = 1'b0;
        done_d    = done_q;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = READ;
                    bin_d     = 8'd0;
                    m2_addr_d = form_addr(baseOffset, 8'd0);
                end
            end
            READ:  state_d = WAIT;
            WAIT: begin
                word_d  = m2ReadVal[31:0];
                state_d = ACCUM;
            end
            ACCUM: begin
                cdf_d     = cdf_sum;
                cdf_min_d = min_now;
                min_set_d = min_now_set;
                if (skip_div) begin
                    state_d   = WRITE;
                    m3_we_d   = 1'b1;
                    m3_addr_d = form_addr(baseOffset, bin_q);
                    level_d   = 8'd0;
                end else begin
                    div_start = 1'b1;
                    state_d   = DIVIDE;
                end
            end
            DIVIDE: begin
                if (div_done) begin
                    state_d   = WRITE;
                    m3_we_d   = 1'b1;
                    m3_addr_d = form_addr(baseOffset, bin_q);
                    level_d   = sat_level(quotient);
                end
            end
            WRITE: begin
                if (bin_q == LAST_BIN) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d   = READ;
                    bin_d     = bin_q + 8'd1;
                    m2_addr_d = form_addr(baseOffset, bin_q + 8'd1);
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: state is written with <= only, so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            cdf_q     <= '0;
            cdf_min_q <= '0;
            min_set_q <= 1'b0;
            word_q    <= '0;
            m2_addr_q <= '0;
            m3_addr_q <= '0;
            level_q   <= '0;
            m3_we_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            cdf_q     <= cdf_d;
            cdf_min_q <= cdf_min_d;
            min_set_q <= min_set_d;
            word_q    <= word_d;
            m2_addr_q <= m2_addr_d;
            m3_addr_q <= m3_addr_d;
            level_q   <= level_d;
            m3_we_q   <= m3_we_d;
            done_q    <= done_d;
        end
    end

    seq_divider #(
        .DIVIDEND_W(NUM_W),
        .DIVISOR_W (COUNT_W)
    ) u_div (
        .clock   (clock),
        .rst_n   (rst_n),
        .start   (div_start),
        .dividend(numerator),
        .divisor (divisor),
        .busy    (unused_div_busy),
        .done    (div_done),
        .quotient(quotient)
    );

    assign unused_rd_hi = ^m2ReadVal[127:32];
    assign m2ReadAddr   = m2_addr_q;
    assign m3WriteAddr  = m3_addr_q;
    assign m3WriteVal   = {120'd0, level_q};
    assign m3WE         = m3_we_q;
    assign done         = done_q;

endmodule
